// File: rtl/xmem_periph_regs_pkg.sv
// Shared definitions for the XMEM peripheral register file.
// Holds the register map offsets, FSM state encoding, default window base
// and the address decode helpers used by the top level.
package xmem_periph_regs_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 16;

  localparam logic [ADDR_W-1:0] DEF_BASE = 16'h1100;

  // Register map offsets relative to the window base
  localparam logic [BYTE_W-1:0] MOT_OFS = 8'h00;
  localparam logic [BYTE_W-1:0] ENC_OFS = 8'h40;
  localparam logic [BYTE_W-1:0] SRV_OFS = 8'h80;
  localparam logic [BYTE_W-1:0] DIG_OFS = 8'hF0;
  localparam logic [BYTE_W-1:0] VER_OFS = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  // Decoded bus address: window hit flag plus byte offset inside the window
  typedef struct packed {
    logic              hit;
    logic [BYTE_W-1:0] ofs;
  } dec_t;

  // Window test done on the base-relative address so an unaligned base still works
  function automatic dec_t decode(input logic [ADDR_W-1:0] addr,
                                  input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] rel;
    dec_t              d;
    rel   = addr - base;
    d.hit = (rel[ADDR_W-1:BYTE_W] == 8'h00);
    d.ofs = rel[BYTE_W-1:0];
    return d;
  endfunction

  // Offset of the low (hi=0) or high (hi=1) byte of channel ch in a region
  function automatic logic [BYTE_W-1:0] reg_ofs(input logic [BYTE_W-1:0] region,
                                                input int unsigned       ch,
                                                input logic              hi);
    return region + 8'(2 * ch) + {7'b0, hi};
  endfunction

endpackage

// File: rtl/xmem_periph_regs_if.sv
// AVR XMEM bus bundle.
//   master : AVR side, drives address/data/strobes, sees read data and SRAM controls
//   slave  : register file side
// Signals: a (addr high byte), ad_i (muxed addr/data in), ad_o/ad_oe (read data
// and its enable), ale, nRD, nWR (active-low strobes), aout (latched addr low
// byte), ramce (SRAM chip enable, active low).
interface xmem_periph_regs_if;
  import xmem_periph_regs_pkg::*;

  logic [BYTE_W-1:0] a;
  logic [BYTE_W-1:0] ad_i;
  logic [BYTE_W-1:0] ad_o;
  logic              ad_oe;
  logic              ale;
  logic              nRD;
  logic              nWR;
  logic [BYTE_W-1:0] aout;
  logic              ramce;

  modport master (output a, ad_i, ale, nRD, nWR,
                  input  ad_o, ad_oe, aout, ramce);

  modport slave  (input  a, ad_i, ale, nRD, nWR,
                  output ad_o, ad_oe, aout, ramce);

endinterface

// File: rtl/xmem_periph_regs_sync_edge.sv
// Two-flop synchroniser with single-cycle edge pulses on the synchronised level.
// Ports: clk, rst (async active-high), d (async input), s (synchronised level),
//        rise/fall (one-clk pulses when s changes).
module xmem_periph_regs_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 synchronise, s3 holds the previous synchronised level for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign s    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/xmem_periph_regs.sv
// AVR XMEM slave register file: motor control/velocity, servo positions,
// atomic encoder reads with per-channel clear, digital inputs and version.
// Ports: clk, rst (async active-high), bus (AVR XMEM slave modport),
//        mot_ctl/mot_vel/srv_pos (channel outputs), enc_cnt (encoder counts in),
//        enc_clr (one-clk clear pulses), dig_in (pre-synchronised inputs).
module xmem_periph_regs
  import xmem_periph_regs_pkg::*;
#(
  parameter logic [15:0] BASE     = DEF_BASE,
  parameter int unsigned N_MOT    = 6,
  parameter int unsigned N_ENC    = 4,
  parameter int unsigned N_SRV    = 6,
  parameter int unsigned SRV_W    = 10,
  parameter logic [15:0] SRV_INIT = 16'd0,
  parameter logic [7:0]  VER_MAJ  = 8'd1,
  parameter logic [7:0]  VER_MIN  = 8'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  xmem_periph_regs_if.slave      bus,
  output logic [2*N_MOT-1:0]     mot_ctl,
  output logic [8*N_MOT-1:0]     mot_vel,
  output logic [SRV_W*N_SRV-1:0] srv_pos,
  input  logic [16*N_ENC-1:0]    enc_cnt,
  output logic [N_ENC-1:0]       enc_clr,
  input  logic [7:0]             dig_in
);

  logic ale_s, ale_rise, ale_fall;
  logic rd_s, rd_rise, rd_fall;
  logic wr_s, wr_rise, wr_fall;

  logic [BYTE_W-1:0] ad_p, ad_d;
  logic [BYTE_W-1:0] a_p, a_d;
  logic [ADDR_W-1:0] addr;
  logic [BYTE_W-1:0] rd_data;
  logic [BYTE_W-1:0] srv_tmp;
  logic [BYTE_W-1:0] rd_mux_c;
  logic              srv_lo_wr_c;
  logic [8*N_ENC-1:0] shadow;

  state_e state, state_nx;
  logic   rd_go_c, wr_go_c;
  dec_t   dec_c;

  // Strobe synchronisers reset to "asserted" so an access in flight across
  // reset never produces a falling edge and is dropped.
  xmem_periph_regs_sync_edge #(.RST_VAL(1'b0)) u_sync_ale (
    .clk(clk), .rst(rst), .d(bus.ale), .s(ale_s), .rise(ale_rise), .fall(ale_fall)
  );
  xmem_periph_regs_sync_edge #(.RST_VAL(1'b0)) u_sync_rd (
    .clk(clk), .rst(rst), .d(bus.nRD), .s(rd_s), .rise(rd_rise), .fall(rd_fall)
  );
  xmem_periph_regs_sync_edge #(.RST_VAL(1'b0)) u_sync_wr (
    .clk(clk), .rst(rst), .d(bus.nWR), .s(wr_s), .rise(wr_rise), .fall(wr_fall)
  );

  // Bus-side outputs
  assign bus.aout  = addr[BYTE_W-1:0];
  assign bus.ramce = (bus.nRD & bus.nWR) ? 1'b1 : ~addr[ADDR_W-1];
  assign bus.ad_oe = ~bus.nRD;
  assign bus.ad_o  = rd_data;

  assign dec_c = decode(addr, BASE);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // FSM next state; rd_go_c/wr_go_c fire once per access on entry to RD/WR.
  // Both strobes low together is a bus fault and leaves the FSM in IDLE.
  always_comb begin
    state_nx = state;
    rd_go_c  = 1'b0;
    wr_go_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ale_s) begin
          state_nx = ST_ADDR;
        end else if (rd_fall && wr_s) begin
          state_nx = ST_RD;
          rd_go_c  = 1'b1;
        end else if (wr_fall && rd_s) begin
          state_nx = ST_WR;
          wr_go_c  = 1'b1;
        end
      end
      ST_ADDR: if (ale_fall) state_nx = ST_IDLE;
      ST_RD:   if (ale_rise || ale_fall || rd_rise) state_nx = ST_IDLE;
      ST_WR:   if (ale_rise || ale_fall || wr_rise) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Data/address pipe matched to the strobe synchronisers, address latch,
  // read data register and the shared servo low-byte temp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_p    <= '0;
      ad_d    <= '0;
      a_p     <= '0;
      a_d     <= '0;
      addr    <= '0;
      rd_data <= '0;
      srv_tmp <= '0;
    end else begin
      ad_p <= bus.ad_i;
      ad_d <= ad_p;
      a_p  <= bus.a;
      a_d  <= a_p;
      if (ale_fall)    addr    <= {a_d, ad_d};
      if (rd_go_c)     rd_data <= rd_mux_c;
      if (srv_lo_wr_c) srv_tmp <= ad_d;
    end
  end

  // Any mapped servo low-byte write loads the shared temp
  always_comb begin
    srv_lo_wr_c = 1'b0;
    for (int unsigned i = 0; i < N_SRV; i++) begin
      if (dec_c.ofs == reg_ofs(SRV_OFS, i, 1'b0)) srv_lo_wr_c = 1'b1;
    end
    srv_lo_wr_c = srv_lo_wr_c & wr_go_c & dec_c.hit;
  end

  // Read mux; unmapped offsets and out-of-window addresses return 0
  always_comb begin
    rd_mux_c = 8'h00;
    if (dec_c.hit) begin
      for (int unsigned i = 0; i < N_MOT; i++) begin
        if (dec_c.ofs == reg_ofs(MOT_OFS, i, 1'b0)) rd_mux_c = {6'b0, mot_ctl[2*i +: 2]};
        if (dec_c.ofs == reg_ofs(MOT_OFS, i, 1'b1)) rd_mux_c = mot_vel[8*i +: 8];
      end
      for (int unsigned i = 0; i < N_ENC; i++) begin
        if (dec_c.ofs == reg_ofs(ENC_OFS, i, 1'b0)) rd_mux_c = enc_cnt[16*i +: 8];
        if (dec_c.ofs == reg_ofs(ENC_OFS, i, 1'b1)) rd_mux_c = shadow[8*i +: 8];
      end
      for (int unsigned i = 0; i < N_SRV; i++) begin
        if (dec_c.ofs == reg_ofs(SRV_OFS, i, 1'b0)) rd_mux_c = srv_pos[SRV_W*i +: 8];
        if (dec_c.ofs == reg_ofs(SRV_OFS, i, 1'b1)) rd_mux_c = 8'(srv_pos[SRV_W*i+8 +: SRV_W-8]);
      end
      if (dec_c.ofs == DIG_OFS)         rd_mux_c = dig_in;
      if (dec_c.ofs == VER_OFS)         rd_mux_c = VER_MAJ;
      if (dec_c.ofs == VER_OFS + 8'd1)  rd_mux_c = VER_MIN;
    end
  end

  // Motor channels
  for (genvar gi = 0; gi < N_MOT; gi++) begin : g_mot
    logic [1:0] ctl_q;
    logic [7:0] vel_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_q <= '0;
        vel_q <= '0;
      end else if (wr_go_c && dec_c.hit) begin
        if (dec_c.ofs == reg_ofs(MOT_OFS, gi, 1'b0)) ctl_q <= ad_d[1:0];
        if (dec_c.ofs == reg_ofs(MOT_OFS, gi, 1'b1)) vel_q <= ad_d;
      end
    end
    assign mot_ctl[2*gi +: 2] = ctl_q;
    assign mot_vel[8*gi +: 8] = vel_q;
  end

  // Encoder channels: low-byte read snapshots the high byte so the pair is
  // atomic; any high-byte write pulses the clear for one clock.
  for (genvar gi = 0; gi < N_ENC; gi++) begin : g_enc
    logic [7:0] shadow_q;
    logic       clr_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_q <= '0;
        clr_q    <= 1'b0;
      end else begin
        clr_q <= wr_go_c && dec_c.hit && (dec_c.ofs == reg_ofs(ENC_OFS, gi, 1'b1));
        if (rd_go_c && dec_c.hit && (dec_c.ofs == reg_ofs(ENC_OFS, gi, 1'b0)))
          shadow_q <= enc_cnt[16*gi+8 +: 8];
      end
    end
    assign shadow[8*gi +: 8] = shadow_q;
    assign enc_clr[gi]       = clr_q;
  end

  // Servo channels: the high-byte write commits {data, temp}
  for (genvar gi = 0; gi < N_SRV; gi++) begin : g_srv
    logic [SRV_W-1:0] pos_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pos_q <= SRV_W'(SRV_INIT);
      end else if (wr_go_c && dec_c.hit && (dec_c.ofs == reg_ofs(SRV_OFS, gi, 1'b1))) begin
        pos_q <= SRV_W'({ad_d, srv_tmp});
      end
    end
    assign srv_pos[SRV_W*gi +: SRV_W] = pos_q;
  end

endmodule

// File: tb/tb_xmem_periph_regs.sv
// Scoreboard bench for xmem_periph_regs: directed scenarios followed by random
// bus traffic checked against a behavioural model of the register map.
module tb_xmem_periph_regs;

  localparam int          N_MOT = 6;
  localparam int          N_ENC = 4;
  localparam int          N_SRV = 6;
  localparam int          SRV_W = 10;
  localparam logic [15:0] BASE  = 16'h1100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xmem_periph_regs_if bus();

  logic [2*N_MOT-1:0]     mot_ctl;
  logic [8*N_MOT-1:0]     mot_vel;
  logic [SRV_W*N_SRV-1:0] srv_pos;
  logic [16*N_ENC-1:0]    enc_cnt = '0;
  logic [N_ENC-1:0]       enc_clr;
  logic [7:0]             dig_in  = 8'h00;

  xmem_periph_regs #(
    .BASE(BASE), .N_MOT(N_MOT), .N_ENC(N_ENC), .N_SRV(N_SRV), .SRV_W(SRV_W),
    .SRV_INIT(16'd0), .VER_MAJ(8'd1), .VER_MIN(8'd0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mot_ctl(mot_ctl), .mot_vel(mot_vel), .srv_pos(srv_pos),
    .enc_cnt(enc_cnt), .enc_clr(enc_clr), .dig_in(dig_in)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the register map
  logic [7:0]  m_ctl    [16] = '{default: 8'h00};
  logic [7:0]  m_vel    [16] = '{default: 8'h00};
  logic [7:0]  m_shadow [16] = '{default: 8'h00};
  logic [15:0] m_pos    [16] = '{default: 16'h0000};
  logic [7:0]  m_tmp   = 8'h00;
  logic [7:0]  last_rd = 8'h00;
  int          m_clr    [16] = '{default: 0};
  int          clr_seen [N_ENC] = '{default: 0};

  logic [7:0] exp_q [$];
  string      name_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_write(input logic [15:0] addr, input logic [7:0] data);
    int ofs, ch;
    bit hi;
    ofs = int'(addr) - int'(BASE);
    if (ofs < 0 || ofs > 255) return;
    ch = (ofs % 64) / 2;
    hi = (ofs % 2) == 1;
    if (ofs < 64) begin
      if (ch < N_MOT) begin
        if (hi) m_vel[ch] = data;
        else    m_ctl[ch] = data & 8'h03;
      end
    end else if (ofs < 128) begin
      if (ch < N_ENC && hi) m_clr[ch]++;
    end else if (ofs < 192) begin
      if (ch < N_SRV) begin
        if (!hi) m_tmp = data;
        else     m_pos[ch] = 16'(((int'(data) << 8) | int'(m_tmp)) & ((1 << SRV_W) - 1));
      end
    end
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] addr);
    int ofs, ch;
    bit hi;
    logic [7:0] r;
    r   = 8'h00;
    ofs = int'(addr) - int'(BASE);
    if (ofs >= 0 && ofs <= 255) begin
      ch = (ofs % 64) / 2;
      hi = (ofs % 2) == 1;
      if (ofs < 64) begin
        if (ch < N_MOT) r = hi ? m_vel[ch] : m_ctl[ch];
      end else if (ofs < 128) begin
        if (ch < N_ENC) begin
          if (hi) r = m_shadow[ch];
          else begin
            r = enc_cnt[16*ch +: 8];
            m_shadow[ch] = enc_cnt[16*ch+8 +: 8];
          end
        end
      end else if (ofs < 192) begin
        if (ch < N_SRV) r = hi ? 8'(m_pos[ch] >> 8) : 8'(m_pos[ch]);
      end else begin
        if (ofs == 240) r = dig_in;
        else if (ofs == 254) r = 8'h01;
        else if (ofs == 255) r = 8'h00;
      end
    end
    last_rd = r;
    return r;
  endfunction

  function automatic logic [63:0] pack_ctl();
    logic [63:0] v = '0;
    for (int i = 0; i < N_MOT; i++) v[2*i +: 2] = m_ctl[i][1:0];
    return v;
  endfunction

  function automatic logic [63:0] pack_vel();
    logic [63:0] v = '0;
    for (int i = 0; i < N_MOT; i++) v[8*i +: 8] = m_vel[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_pos();
    logic [63:0] v = '0;
    for (int i = 0; i < N_SRV; i++) v[SRV_W*i +: SRV_W] = m_pos[i][SRV_W-1:0];
    return v;
  endfunction

  task automatic check_outputs();
    check("mot_ctl", 64'(mot_ctl), pack_ctl());
    check("mot_vel", 64'(mot_vel), pack_vel());
    check("srv_pos", 64'(srv_pos), pack_pos());
  endtask

  task automatic addr_phase(input logic [15:0] addr);
    @(posedge clk); #1;
    bus.ale  = 1'b1;
    bus.a    = addr[15:8];
    bus.ad_i = addr[7:0];
    repeat (3) @(posedge clk); #1;
    bus.ale = 1'b0;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    addr_phase(addr);
    model_write(addr, data);
    bus.ad_i = data;
    bus.nWR  = 1'b0;
    repeat (4) @(posedge clk); #1;
    bus.nWR = 1'b1;
    repeat (3) @(posedge clk); #1;
  endtask

  // Read with nRD held exactly 4 clocks: data must be valid by then
  task automatic do_read(input logic [15:0] addr, input string name,
                         input bit use_lit, input logic [7:0] lit);
    logic [7:0] e;
    addr_phase(addr);
    e = model_read(addr);
    if (use_lit) e = lit;
    exp_q.push_back(e);
    name_q.push_back(name);
    bus.nRD = 1'b0;
    repeat (4) @(posedge clk); #1;
    bus.nRD = 1'b1;
    repeat (3) @(posedge clk); #1;
  endtask

  // Monitor: each completed read (ad_oe dropping) pops one expected byte
  logic prev_oe = 1'b0;
  always @(negedge clk) begin : mon
    logic [7:0] e;
    string      nm;
    if (prev_oe && !bus.ad_oe) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: got %0h, expected no read", bus.ad_o);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, 64'(bus.ad_o), 64'(e));
      end
    end
    prev_oe = bus.ad_oe;
    for (int i = 0; i < N_ENC; i++) if (enc_clr[i]) clr_seen[i]++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addr;
    int          r;

    bus.ale = 1'b0; bus.nRD = 1'b1; bus.nWR = 1'b1;
    bus.a   = 8'h00; bus.ad_i = 8'h00;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset state
    check("rst_ad_o",   64'(bus.ad_o),  64'h00);
    check("rst_aout",   64'(bus.aout),  64'h00);
    check("rst_ramce",  64'(bus.ramce), 64'h1);
    check("rst_enc_clr",64'(enc_clr),   64'h0);
    check_outputs();

    // Reset during a write to 0x1101 drops the write
    addr_phase(16'h1101);
    bus.ad_i = 8'h80;
    bus.nWR  = 1'b0;
    rst      = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    bus.nWR = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rstwr_mot_vel0", 64'(mot_vel[7:0]), 64'h00);
    check("rstwr_ramce",    64'(bus.ramce),    64'h1);
    check("rstwr_aout",     64'(bus.aout),     64'h00);
    check("rstwr_no_clr",   64'(clr_seen[0] + clr_seen[1] + clr_seen[2] + clr_seen[3]), 64'd0);

    // Motor control/velocity
    do_write(16'h1100, 8'hFF);
    check("mot_ctl0", 64'(mot_ctl[1:0]), 64'h3);
    do_read(16'h1100, "rd_mot_ctl0", 1'b1, 8'h03);
    do_write(16'h1101, 8'h80);
    do_read(16'h1101, "rd_mot_vel0", 1'b1, 8'h80);
    check_outputs();

    // Atomic encoder read
    enc_cnt[15:0] = 16'h12FE;
    do_read(16'h1140, "rd_enc0_lo", 1'b1, 8'hFE);
    enc_cnt[15:0] = 16'h1301;
    do_read(16'h1141, "rd_enc0_hi", 1'b1, 8'h12);

    // Servo commit only on high byte
    do_write(16'h1182, 8'h34);
    check("srv1_before_hi", 64'(srv_pos[SRV_W +: SRV_W]), 64'h000);
    do_write(16'h1183, 8'hFF);
    check("srv1_after_hi", 64'(srv_pos[SRV_W +: SRV_W]), 64'h334);
    do_read(16'h1182, "rd_srv1_lo", 1'b1, 8'h34);
    do_read(16'h1183, "rd_srv1_hi", 1'b1, 8'h03);

    // Encoder clear pulse
    do_write(16'h1143, 8'h00);
    check("enc_clr1_cycles", 64'(clr_seen[1]), 64'd1);

    // Unmapped encoder, digital inputs, version, read-only write
    dig_in = 8'hA5;
    do_read(16'h1148, "rd_enc4_unmapped", 1'b1, 8'h00);
    do_read(16'h11F0, "rd_dig_in",        1'b1, 8'hA5);
    do_read(16'h11FE, "rd_ver_maj",       1'b1, 8'h01);
    do_read(16'h11FF, "rd_ver_min",       1'b1, 8'h00);
    do_write(16'h11FE, 8'h77);
    do_read(16'h11FE, "rd_ver_maj_ro",    1'b1, 8'h01);
    check_outputs();

    // Bus fault: both strobes low, no read update and no write commit
    addr_phase(16'h1101);
    exp_q.push_back(last_rd);
    name_q.push_back("fault_no_read");
    bus.ad_i = 8'h55;
    bus.nRD  = 1'b0;
    bus.nWR  = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("fault_ad_o", 64'(bus.ad_o), 64'(last_rd));
    bus.nRD = 1'b1;
    bus.nWR = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_outputs();

    // Read outside the window drives SRAM enable
    addr_phase(16'h9000);
    exp_q.push_back(model_read(16'h9000));
    name_q.push_back("rd_9000");
    bus.nRD = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rd_9000_ramce", 64'(bus.ramce), 64'h0);
    check("rd_9000_aout",  64'(bus.aout),  64'h00);
    repeat (2) @(posedge clk); #1;
    bus.nRD = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("idle_ramce", 64'(bus.ramce), 64'h1);

    // Random traffic against the model
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < N_ENC; i++) enc_cnt[16*i +: 16] = 16'($urandom);
      dig_in = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6)      addr = BASE + 16'($urandom_range(0, 3) * 64 + $urandom_range(0, 15));
      else if (r < 9) addr = BASE + 16'($urandom_range(0, 255));
      else            addr = 16'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(addr, 8'($urandom));
      else                           do_read(addr, "rand_read", 1'b0, 8'h00);
      check_outputs();
    end

    repeat (5) @(posedge clk); #1;
    for (int i = 0; i < N_ENC; i++) check("enc_clr_count", 64'(clr_seen[i]), 64'(m_clr[i]));
    check("reads_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
